eth_phy_mgmt_ctrl: RTL and testbench
====================================

# eth_phy_mgmt_ctrl

Management-plane controller for the external 10/100 MII Ethernet PHY. It drives the PHY's MDC/MDIO pins to write the basic control register once after reset, then continuously polls link and auto-negotiation results. It presents link_up / speed_100 / full_duplex to the top level, where they feed the TSE MAC status inputs and the board LEDs. It runs beside the Nios II system in the clk_100m domain; firmware is not involved.

## Interface
- CLK_FREQ, 100_000_000: sys_clk frequency in Hz.
- MDC_FREQ, 2_500_000: MDC frequency in Hz; DIV = CLK_FREQ/(2*MDC_FREQ), must be ≥ 2.
- PHY_ADDR, 5'h01: PHY MDIO address.
- INIT_CYCLES, 1_000_000: idle sys_clk cycles between reset release and the first frame, for PHY power-up.
- POLL_CYCLES, 10_000_000: idle cycles between poll rounds.
- sys_clk  in  1  system clock; single clock domain.
- sys_rst_n  in  1  asynchronous, active-low reset.
- soft_rst  in  1  synchronous pulse; aborts any frame and restarts from INIT_WAIT.
- eth_mdc  out  1  MDIO clock.
- eth_mdio  inout  1  MDIO data, open-drain style; released = Z.
- link_up  out  1  PHY link up and auto-negotiation complete.
- speed_100  out  1  1 = 100 Mb/s, 0 = 10 Mb/s; valid when link_up.
- full_duplex  out  1  resolved duplex; valid when link_up.
- mdio_err  out  1  one-cycle pulse when a read sees no PHY.
- busy  out  1  high while a frame is on the wire.

## Operation
- Main FSM: INIT_WAIT → WR_BMCR → RD_BMSR → (RD_ANLPAR) → POLL_WAIT → RD_BMSR …
- INIT_WAIT: count INIT_CYCLES, then go to WR_BMCR.
- WR_BMCR: write reg 0 = 16'h1200 (AN enable + restart AN).
- RD_BMSR: read reg 1.
  - Bit 2 (link) and bit 5 (AN complete) both 1 → RD_ANLPAR.
  - Otherwise clear link_up, speed_100 and full_duplex, then go to POLL_WAIT.
- RD_ANLPAR: read reg 5 and resolve in priority order:
  - bit 8 → 100FD
  - else bit 7 → 100HD
  - else bit 6 → 10FD
  - else 10HD
  - Set link_up = 1, then go to POLL_WAIT.
- POLL_WAIT: count POLL_CYCLES, then go to RD_BMSR.
- Frame format, 64 bits MSB-first:
  - 32 × '1' preamble
  - ST = 01
  - OP = 01 (write) / 10 (read)
  - PHYAD[4:0], REGAD[4:0]
  - TA: write drives 10; read releases and samples the second TA bit
  - 16 data bits
- Read turnaround and data bits are driven Z by the controller. If the sampled TA bit ≠ 0 (no PHY, bus pulled high):
  - pulse mdio_err
  - clear link_up, speed_100 and full_duplex
  - go to POLL_WAIT
- Status outputs are updated only at the end of a frame and are never glitched mid-frame.
- soft_rst or sys_rst_n asserted mid-frame: MDIO goes Z and MDC goes 0 immediately, the counters clear, and the FSM enters INIT_WAIT. Status outputs keep their values on soft_rst and clear on sys_rst_n.

## Timing
- Reset values:
  - eth_mdc = 0
  - eth_mdio = Z
  - link_up = 0, speed_100 = 0, full_duplex = 0
  - mdio_err = 0, busy = 0
- MDC: toggles every DIV cycles while busy, period 2·DIV; held at 0 when idle.
- Driven bits change one cycle after the MDC falling edge. Read bits are sampled on the MDC rising edge.
- Frame length: 64 MDC periods = 128·DIV cycles. busy rises with the first preamble bit and falls one cycle after the last MDC falling edge.
- Status latency: outputs update one cycle after busy falls on the BMSR frame (link down) or the ANLPAR frame (link up).
- soft_rst takes effect on the next sys_clk edge. It has priority over every FSM transition.

## Structure
- Package eth_mgmt_pkg holds:
  - register addresses REG_BMCR = 0, REG_BMSR = 1, REG_ANLPAR = 5
  - opcodes OP_WR / OP_RD
  - BMCR_INIT value
  - BMSR / ANLPAR bit indices
  - FSM state enum
- Sub-module mdio_xfer handles the bit level:
  - inputs: start, op, phy, reg, wdata
  - outputs: rdata, ta_ok, done
  - owns the MDC divider, 6-bit bit counter and 64-bit shift register
- The top FSM sequences mdio_xfer, holds the wait counters and resolves status.

## Test plan
- Bench parameters: DIV = 2, INIT_CYCLES = 20, POLL_CYCLES = 50, PHY model at address 1.
- Reset/first write: release sys_rst_n. All outputs hold reset values through INIT_WAIT, then the captured MDIO sequence is 32×1, 01, 01, 00001, 00000, 10, 16'h1200.
- Link 100FD: BMSR = 16'h782D, ANLPAR = 16'h01E1 → link_up = 1, speed_100 = 1, full_duplex = 1, one cycle after the ANLPAR frame ends.
- Link 10FD: ANLPAR = 16'h0041 → speed_100 = 0, full_duplex = 1. Then BMSR = 16'h7809 → link_up, speed_100 and full_duplex all 0, with no reg-5 frame issued.
- PHY absent: MDIO pulled high on reads → single-cycle mdio_err on every poll, link_up stays 0, the FSM keeps polling.
- Abort: assert soft_rst at bit 40 of a BMSR read → MDIO Z and MDC 0 on the next edge, busy = 0, then after 20 cycles a fresh WR_BMCR frame. Link status is retained throughout.

Source files
------------

// File: rtl/eth_mgmt_pkg.sv
// Shared constants, FSM state type and frame helpers for the PHY management controller.
package eth_mgmt_pkg;

  localparam logic [4:0] REG_BMCR   = 5'd0;
  localparam logic [4:0] REG_BMSR   = 5'd1;
  localparam logic [4:0] REG_ANLPAR = 5'd5;

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  // Auto-negotiation enable + restart auto-negotiation
  localparam logic [15:0] BMCR_INIT = 16'h1200;

  localparam int unsigned BMSR_LINK_BIT    = 2;
  localparam int unsigned BMSR_AN_DONE_BIT = 5;
  localparam int unsigned ANLPAR_100FD_BIT = 8;
  localparam int unsigned ANLPAR_100HD_BIT = 7;
  localparam int unsigned ANLPAR_10FD_BIT  = 6;

  typedef enum logic [2:0] {
    StInitWait,
    StWrBmcr,
    StRdBmsr,
    StRdAnlpar,
    StPollWait
  } mgmt_state_e;

  typedef struct packed {
    logic speed_100;
    logic full_duplex;
  } link_mode_t;

  // Full 64-bit clause-22 frame, MSB goes out first. Read TA/data bits are
  // never driven, so their contents here are don't-care.
  function automatic logic [63:0] mdio_frame(input logic [1:0]  op,
                                             input logic [4:0]  phy,
                                             input logic [4:0]  regad,
                                             input logic [15:0] wdata);
    logic [1:0]  ta;
    logic [15:0] data;
    ta   = (op == OP_WR) ? 2'b10 : 2'b11;
    data = (op == OP_WR) ? wdata : 16'h0000;
    return {32'hFFFF_FFFF, 2'b01, op, phy, regad, ta, data};
  endfunction

  // Highest common ability advertised by the link partner.
  function automatic link_mode_t resolve_anlpar(input logic [15:0] anlpar);
    link_mode_t m;
    if (anlpar[ANLPAR_100FD_BIT]) begin
      m = '{speed_100: 1'b1, full_duplex: 1'b1};
    end else if (anlpar[ANLPAR_100HD_BIT]) begin
      m = '{speed_100: 1'b1, full_duplex: 1'b0};
    end else if (anlpar[ANLPAR_10FD_BIT]) begin
      m = '{speed_100: 1'b0, full_duplex: 1'b1};
    end else begin
      m = '{speed_100: 1'b0, full_duplex: 1'b0};
    end
    return m;
  endfunction

endpackage

// File: rtl/mdio_xfer.sv
// Bit-level MDIO engine: MDC divider, 64-bit frame shifter, TA check and read capture.
module mdio_xfer
  import eth_mgmt_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  phy,
  input  logic [4:0]  regad,
  input  logic [15:0] wdata,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic        mdc,
  output logic        busy,
  output logic [15:0] rdata,
  output logic        ta_ok,
  output logic        done
);

  localparam int unsigned DivW = $clog2(DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

  logic            active_q, active_d;
  logic            mdc_q, mdc_d;
  logic [DivW-1:0] div_q, div_d;
  logic            fall_q, fall_d;
  logic [5:0]      bit_q, bit_d;
  logic [63:0]     sr_q, sr_d;
  logic            oe_q, oe_d;
  logic            is_rd_q, is_rd_d;
  logic            ta_q, ta_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            done_q, done_d;

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      mdc_q    <= 1'b0;
      div_q    <= '0;
      fall_q   <= 1'b0;
      bit_q    <= '0;
      sr_q     <= '0;
      oe_q     <= 1'b0;
      is_rd_q  <= 1'b0;
      ta_q     <= 1'b1;
      rdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      mdc_q    <= mdc_d;
      div_q    <= div_d;
      fall_q   <= fall_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      oe_q     <= oe_d;
      is_rd_q  <= is_rd_d;
      ta_q     <= ta_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
    end
  end

  // Frame sequencing: bits shift one cycle after MDC falls, reads sample on MDC rise
  always_comb begin
    active_d = active_q;
    mdc_d    = mdc_q;
    div_d    = div_q;
    fall_d   = 1'b0;
    bit_d    = bit_q;
    sr_d     = sr_q;
    oe_d     = oe_q;
    is_rd_d  = is_rd_q;
    ta_d     = ta_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    if (abort) begin
      active_d = 1'b0;
      mdc_d    = 1'b0;
      div_d    = '0;
      bit_d    = '0;
      sr_d     = '0;
      oe_d     = 1'b0;
    end else if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        mdc_d    = 1'b0;
        div_d    = '0;
        bit_d    = '0;
        sr_d     = mdio_frame(op, phy, regad, wdata);
        oe_d     = 1'b1;
        is_rd_d  = (op == OP_RD);
        ta_d     = 1'b1;
      end
    end else begin
      if (div_q == DivLast) begin
        div_d  = '0;
        mdc_d  = ~mdc_q;
        fall_d = mdc_q;
        if (!mdc_q && is_rd_q) begin
          // Bit 47 is the second TA bit; 48..63 carry data MSB-first
          if (bit_q == 6'd47) begin
            ta_d = mdio_in;
          end else if (bit_q >= 6'd48) begin
            rdata_d = {rdata_q[14:0], mdio_in};
          end
        end
      end else begin
        div_d = div_q + DivW'(1);
      end
      if (fall_q) begin
        if (bit_q == 6'd63) begin
          active_d = 1'b0;
          div_d    = '0;
          sr_d     = '0;
          oe_d     = 1'b0;
          done_d   = 1'b1;
        end else begin
          bit_d = bit_q + 6'd1;
          sr_d  = {sr_q[62:0], 1'b0};
          // Reads release the line from the first TA bit (46) onwards
          oe_d  = !(is_rd_q && bit_q >= 6'd45);
        end
      end
    end
  end

  assign mdio_out = sr_q[63];
  assign mdio_oe  = oe_q;
  assign mdc      = mdc_q;
  assign busy     = active_q;
  assign rdata    = rdata_q;
  assign ta_ok    = ~ta_q;
  assign done     = done_q;

endmodule

// File: rtl/eth_phy_mgmt_ctrl.sv
// PHY management controller: one BMCR write after power-up, then periodic link polling.
module eth_phy_mgmt_ctrl
  import eth_mgmt_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned MDC_FREQ    = 2_500_000,
  parameter logic [4:0]  PHY_ADDR    = 5'h01,
  parameter int unsigned INIT_CYCLES = 1_000_000,
  parameter int unsigned POLL_CYCLES = 10_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic soft_rst,
  output logic eth_mdc,
  inout  wire  eth_mdio,
  output logic link_up,
  output logic speed_100,
  output logic full_duplex,
  output logic mdio_err,
  output logic busy
);

  // Half MDC period in sys_clk cycles; must be at least 2
  localparam int unsigned DIV = CLK_FREQ / (2 * MDC_FREQ);

  mgmt_state_e state_q, state_d;
  logic [31:0] wait_q, wait_d;
  logic        launched_q, launched_d;
  logic        link_q, link_d;
  logic        spd_q, spd_d;
  logic        dup_q, dup_d;
  logic        err_q, err_d;

  logic        xfer_start;
  logic [1:0]  xfer_op;
  logic [4:0]  xfer_reg;
  logic [15:0] xfer_wdata;
  logic        xfer_busy;
  logic        xfer_done;
  logic        xfer_ta_ok;
  logic [15:0] xfer_rdata;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdio_in;
  logic        bmsr_up;
  link_mode_t  mode;
  logic        unused_rdata;

  assign eth_mdio = mdio_oe ? mdio_out : 1'bz;
  assign mdio_in  = eth_mdio;

  assign bmsr_up      = xfer_rdata[BMSR_LINK_BIT] && xfer_rdata[BMSR_AN_DONE_BIT];
  assign mode         = resolve_anlpar(xfer_rdata);
  assign unused_rdata = ^xfer_rdata;

  mdio_xfer #(
    .DIV (DIV)
  ) u_xfer (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .abort    (soft_rst),
    .start    (xfer_start),
    .op       (xfer_op),
    .phy      (PHY_ADDR),
    .regad    (xfer_reg),
    .wdata    (xfer_wdata),
    .mdio_in  (mdio_in),
    .mdio_out (mdio_out),
    .mdio_oe  (mdio_oe),
    .mdc      (eth_mdc),
    .busy     (xfer_busy),
    .rdata    (xfer_rdata),
    .ta_ok    (xfer_ta_ok),
    .done     (xfer_done)
  );

  // State register, wait counter and one-shot frame launch flag
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StInitWait;
      wait_q     <= '0;
      launched_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      launched_q <= launched_d;
    end
  end

  // Next-state: soft_rst overrides every transition
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    if (soft_rst) begin
      state_d = StInitWait;
    end else begin
      case (state_q)
        StInitWait: begin
          if (wait_q == 32'(INIT_CYCLES - 1)) state_d = StWrBmcr;
          else                                wait_d  = wait_q + 32'd1;
        end
        StWrBmcr: begin
          if (xfer_done) state_d = StRdBmsr;
        end
        StRdBmsr: begin
          if (xfer_done) state_d = (xfer_ta_ok && bmsr_up) ? StRdAnlpar : StPollWait;
        end
        StRdAnlpar: begin
          if (xfer_done) state_d = StPollWait;
        end
        StPollWait: begin
          if (wait_q == 32'(POLL_CYCLES - 1)) state_d = StRdBmsr;
          else                                wait_d  = wait_q + 32'd1;
        end
        default: state_d = StInitWait;
      endcase
    end
  end

  // Outputs: frame request per state and end-of-frame status resolution
  always_comb begin
    xfer_op    = OP_RD;
    xfer_reg   = REG_BMSR;
    xfer_wdata = 16'h0000;
    xfer_start = 1'b0;
    link_d     = link_q;
    spd_d      = spd_q;
    dup_d      = dup_q;
    err_d      = 1'b0;
    case (state_q)
      StWrBmcr: begin
        xfer_op    = OP_WR;
        xfer_reg   = REG_BMCR;
        xfer_wdata = BMCR_INIT;
      end
      StRdAnlpar: xfer_reg = REG_ANLPAR;
      default: ;
    endcase
    if (state_q == StWrBmcr || state_q == StRdBmsr || state_q == StRdAnlpar) begin
      xfer_start = !launched_q && !xfer_busy && !soft_rst;
    end
    if (!soft_rst && xfer_done) begin
      if (state_q == StRdBmsr || state_q == StRdAnlpar) begin
        if (!xfer_ta_ok) begin
          err_d  = 1'b1;
          link_d = 1'b0;
          spd_d  = 1'b0;
          dup_d  = 1'b0;
        end else if (state_q == StRdBmsr) begin
          // Link up here only means ANLPAR is read next; status moves after that
          if (!bmsr_up) begin
            link_d = 1'b0;
            spd_d  = 1'b0;
            dup_d  = 1'b0;
          end
        end else begin
          link_d = 1'b1;
          spd_d  = mode.speed_100;
          dup_d  = mode.full_duplex;
        end
      end
    end
  end

  // Launch flag re-arms whenever the FSM changes state
  always_comb begin
    if (soft_rst || state_d != state_q) launched_d = 1'b0;
    else                                launched_d = launched_q | xfer_start;
  end

  // Status registers: cleared only by sys_rst_n, held across soft_rst
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      link_q <= 1'b0;
      spd_q  <= 1'b0;
      dup_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      link_q <= link_d;
      spd_q  <= spd_d;
      dup_q  <= dup_d;
      err_q  <= err_d;
    end
  end

  assign link_up     = link_q;
  assign speed_100   = spd_q;
  assign full_duplex = dup_q;
  assign mdio_err    = err_q;
  assign busy        = xfer_busy;

endmodule

// File: tb/tb_eth_phy_mgmt_ctrl.sv
// Bench for eth_phy_mgmt_ctrl: behavioural PHY on the MDIO wire plus a rule-level status model.
`timescale 1ns/1ps
module tb_eth_phy_mgmt_ctrl;

  localparam int INIT_CYC = 20;
  localparam int POLL_CYC = 50;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic soft_rst = 1'b0;
  wire  eth_mdio;
  logic eth_mdc, link_up, speed_100, full_duplex, mdio_err, busy;

  // PHY model state
  logic        phy_drv = 1'b0;
  logic        phy_val = 1'b0;
  logic        phy_present = 1'b1;
  logic [15:0] bmsr_val = 16'h782D;
  logic [15:0] anlpar_val = 16'h01E1;
  int          bit_idx = 0;
  logic [63:0] frame_sr = '0;
  logic [63:0] frame_q[$];
  logic        rd_frame = 1'b0;
  logic [15:0] rd_data = '0;

  int total = 0;
  int bad = 0;
  logic [2:0] exp_st = 3'b000;

  // Released line reads low so a release is visible against driven preamble ones
  pulldown (eth_mdio);
  assign eth_mdio = phy_drv ? phy_val : 1'bz;

  always #5 sys_clk = ~sys_clk;

  eth_phy_mgmt_ctrl #(
    .CLK_FREQ    (100_000_000),
    .MDC_FREQ    (25_000_000),
    .PHY_ADDR    (5'h01),
    .INIT_CYCLES (INIT_CYC),
    .POLL_CYCLES (POLL_CYC)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .soft_rst    (soft_rst),
    .eth_mdc     (eth_mdc),
    .eth_mdio    (eth_mdio),
    .link_up     (link_up),
    .speed_100   (speed_100),
    .full_duplex (full_duplex),
    .mdio_err    (mdio_err),
    .busy        (busy)
  );

  // Capture every bit on MDC rise; a full 64-bit frame goes to the queue
  always @(posedge eth_mdc) begin
    frame_sr = {frame_sr[62:0], eth_mdio};
    bit_idx  = bit_idx + 1;
    if (bit_idx == 64) begin
      frame_q.push_back(frame_sr);
      bit_idx = 0;
    end
  end

  always @(posedge sys_clk) begin
    if (!busy) begin
      bit_idx  = 0;
      frame_sr = '0;
    end
  end

  // PHY answers reads after MDC falls; absent PHY looks like a pulled-high bus
  always @(negedge eth_mdc) begin
    if (bit_idx == 46) begin
      rd_frame = (frame_sr[11:10] == 2'b10) && (frame_sr[9:5] == 5'd1);
      rd_data  = (frame_sr[4:0] == 5'd1) ? bmsr_val :
                 (frame_sr[4:0] == 5'd5) ? anlpar_val : 16'h0000;
    end
    if (bit_idx < 46) rd_frame = 1'b0;
    if (rd_frame && bit_idx >= 47 && bit_idx <= 63) begin
      phy_drv = 1'b1;
      if (!phy_present)      phy_val = 1'b1;
      else if (bit_idx == 47) phy_val = 1'b0;
      else                   phy_val = rd_data[63 - bit_idx];
    end else begin
      phy_drv = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] model_status(input logic [15:0] bmsr, input logic [15:0] anl);
    if (!(bmsr[2] && bmsr[5])) return 3'b000;
    if (anl[8]) return 3'b111;
    if (anl[7]) return 3'b110;
    if (anl[6]) return 3'b101;
    return 3'b100;
  endfunction

  function automatic logic [45:0] rd_hdr(input logic [4:0] regad);
    return {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, regad};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int budget, output bit ok);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    ok = (busy === lvl);
  endtask

  // Returns half a cycle after busy falls with the captured frame
  task automatic next_frame(input string tag, output logic [63:0] f);
    bit ok1, ok2;
    wait_busy(1'b1, 400, ok1);
    wait_busy(1'b0, 400, ok2);
    check({tag, "_frame_done"}, {62'd0, ok1, ok2}, 64'd3);
    check({tag, "_frame_count"}, 64'(frame_q.size()), 64'd1);
    f = (frame_q.size() > 0) ? frame_q.pop_front() : '0;
    frame_q.delete();
  endtask

  function automatic logic [63:0] st_obs();
    return {61'd0, link_up, speed_100, full_duplex};
  endfunction

  task automatic poll_round(input logic [15:0] bmsr, input logic [15:0] anl, input string tag);
    logic [63:0] f;
    logic [2:0]  want;
    bmsr_val   = bmsr;
    anlpar_val = anl;
    want       = model_status(bmsr, anl);
    next_frame({tag, "_bmsr"}, f);
    check({tag, "_bmsr_hdr"}, {18'd0, f[63:18]}, {18'd0, rd_hdr(5'd1)});
    check({tag, "_bmsr_hold"}, st_obs(), {61'd0, exp_st});
    @(posedge sys_clk); #1;
    if (!(bmsr[2] && bmsr[5])) begin
      check({tag, "_down"}, st_obs(), 64'd0);
      exp_st = 3'b000;
    end else begin
      check({tag, "_bmsr_nochg"}, st_obs(), {61'd0, exp_st});
      next_frame({tag, "_anlpar"}, f);
      check({tag, "_anlpar_hdr"}, {18'd0, f[63:18]}, {18'd0, rd_hdr(5'd5)});
      check({tag, "_anlpar_hold"}, st_obs(), {61'd0, exp_st});
      @(posedge sys_clk); #1;
      check({tag, "_status"}, st_obs(), {61'd0, want});
      exp_st = want;
    end
  endtask

  initial begin
    logic [63:0] f;
    logic [63:0] wr_exp;
    int          n;
    bit          dirty;
    logic [15:0] rb, ra;
    wr_exp = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1200};

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_mdc", 64'(eth_mdc), 64'd0);
    check("rst_mdio_released", 64'(eth_mdio), 64'd0);
    check("rst_status", {60'd0, link_up, speed_100, full_duplex, mdio_err}, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Quiet for INIT_CYCLES, then the BMCR write
    sys_rst_n = 1'b1;
    n = 0;
    dirty = 1'b0;
    while (busy !== 1'b1 && n < 200) begin
      @(posedge sys_clk); #1;
      n++;
      if (busy !== 1'b1 && (eth_mdc !== 1'b0 || eth_mdio !== 1'b0 || link_up !== 1'b0 ||
                            mdio_err !== 1'b0)) dirty = 1'b1;
    end
    check("init_quiet", 64'(dirty), 64'd0);
    check("init_len", 64'(n), 64'(INIT_CYC + 1));
    next_frame("wr", f);
    check("wr_bmcr_frame", f, wr_exp);

    // Directed link modes, then link loss without an ANLPAR read
    poll_round(16'h782D, 16'h01E1, "fd100");
    poll_round(16'h782D, 16'h0041, "fd10");
    poll_round(16'h7809, 16'h01E1, "down");
    poll_round(16'h782D, 16'h0081, "hd100");
    poll_round(16'h782D, 16'h0021, "hd10");

    // Randomized register contents against the rule model
    for (int i = 0; i < 8; i++) begin
      rb = 16'($urandom);
      ra = 16'($urandom);
      if ($urandom_range(0, 2) != 0) rb = rb | 16'h0024;
      poll_round(rb, ra, $sformatf("rnd%0d", i));
    end

    // Absent PHY: TA reads high on every poll
    phy_present = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_frame($sformatf("abs%0d", i), f);
      check($sformatf("abs%0d_hdr", i), {18'd0, f[63:18]}, {18'd0, rd_hdr(5'd1)});
      check($sformatf("abs%0d_err_pre", i), 64'(mdio_err), 64'd0);
      @(posedge sys_clk); #1;
      check($sformatf("abs%0d_err", i), 64'(mdio_err), 64'd1);
      check($sformatf("abs%0d_status", i), st_obs(), 64'd0);
      @(posedge sys_clk); #1;
      check($sformatf("abs%0d_err_end", i), 64'(mdio_err), 64'd0);
    end
    exp_st = 3'b000;
    phy_present = 1'b1;
    poll_round(16'h782D, 16'h01E1, "relink");

    // Abort a BMSR read while bit 40 (PHYAD LSB, a driven 1) is on the wire
    bmsr_val = 16'h782D;
    n = 0;
    while (busy !== 1'b1 && n < 400) begin @(negedge sys_clk); n++; end
    n = 0;
    while (bit_idx != 40 && n < 400) begin @(negedge sys_clk); n++; end
    check("abort_reach_bit40", 64'(bit_idx), 64'd40);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("abort_bit40_driven", 64'(eth_mdio), 64'd1);
    soft_rst = 1'b1;
    @(posedge sys_clk); #1;
    check("abort_mdc", 64'(eth_mdc), 64'd0);
    check("abort_mdio_released", 64'(eth_mdio), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_status_kept", st_obs(), {61'd0, exp_st});
    @(negedge sys_clk);
    soft_rst = 1'b0;
    frame_q.delete();
    n = 0;
    dirty = 1'b0;
    while (busy !== 1'b1 && n < 200) begin
      @(posedge sys_clk); #1;
      n++;
      if (st_obs() !== {61'd0, exp_st}) dirty = 1'b1;
    end
    check("abort_restart_len", 64'(n), 64'(INIT_CYC + 1));
    check("abort_status_retained", 64'(dirty), 64'd0);
    next_frame("abort_wr", f);
    check("abort_wr_bmcr_frame", f, wr_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
